// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU command codes, register-index width, forwarding selects.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips_pkg;

  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;

  // Where an operand value is taken from.
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/id_exe_stage_fwd.sv
// Operand forwarding for one source index: MEM result beats WB value beats the registered value.
// Latency: purely combinational.
// Backpressure: none; stalls for load-use hazards are applied upstream through freeze.
module forwarding_unit
  import mips_pkg::*;
#(
  parameter int DW = 32
) (
  input  reg_idx_t        src,
  input  logic [DW-1:0]   reg_val,
  input  logic            mem_wb_en,
  input  reg_idx_t        mem_dest,
  input  logic [DW-1:0]   mem_result,
  input  logic            wb_wb_en,
  input  reg_idx_t        wb_dest,
  input  logic [DW-1:0]   wb_value,
  output logic [DW-1:0]   value
);

  fwd_sel_t sel;

  // Pick the youngest producer of src; r0 is hard-wired and never forwarded.
  always_comb begin
    sel = FWD_REG;
    if (src != '0) begin
      if (mem_wb_en && (mem_dest == src)) begin
        sel = FWD_MEM;
      end else if (wb_wb_en && (wb_dest == src)) begin
        sel = FWD_WB;
      end
    end
  end

  // Steer the selected source onto the operand.
  always_comb begin
    value = reg_val;
    case (sel)
      FWD_MEM: value = mem_result;
      FWD_WB:  value = wb_value;
      default: value = reg_val;
    endcase
  end

endmodule

// File: rtl/id_exe_stage.sv
// ID/EX pipeline register feeding the ALU; MEM/WB operand forwarding compiled in with FORWARDING_EN.
// Latency: one cycle from id_* capture to outputs; forwarding muxes after the register add none.
// Backpressure: freeze holds the held instruction, flush loads a bubble and overrides freeze.
module id_exe_stage
  import mips_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [DW-1:0]   id_pc,
  input  logic [DW-1:0]   id_reg1,
  input  logic [DW-1:0]   id_reg2,
  input  logic [DW-1:0]   id_imm,
  input  logic            id_use_imm,
  input  logic [3:0]      id_exe_cmd,
  input  reg_idx_t        id_src1,
  input  reg_idx_t        id_src2,
  input  reg_idx_t        id_dest,
  input  logic            id_wb_en,
  input  logic            id_mem_r_en,
  input  logic            id_mem_w_en,
  input  logic            mem_wb_en,
  input  reg_idx_t        mem_dest,
  input  logic [DW-1:0]   mem_result,
  input  logic            wb_wb_en,
  input  reg_idx_t        wb_dest,
  input  logic [DW-1:0]   wb_value,
  output logic [DW-1:0]   alu_in1,
  output logic [DW-1:0]   alu_in2,
  output logic [3:0]      alu_cmd,
  output logic            exe_valid,
  output logic [DW-1:0]   exe_pc,
  output reg_idx_t        exe_dest,
  output logic            exe_wb_en,
  output logic            exe_mem_r_en,
  output logic            exe_mem_w_en,
  output logic [DW-1:0]   exe_store_val
);

  // One held instruction; the all-zero pattern is the bubble.
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] reg1;
    logic [DW-1:0] reg2;
    logic [DW-1:0] imm;
    logic          use_imm;
    logic [3:0]    cmd;
    reg_idx_t      src1;
    reg_idx_t      src2;
    reg_idx_t      dest;
    logic          wb_en;
    logic          mem_r_en;
    logic          mem_w_en;
  } exe_reg_t;

  exe_reg_t      q;
  exe_reg_t      d_cap;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;

  // Build the capture image; an invalid decode slot turns into a bubble.
  always_comb begin
    d_cap = '0;
    if (id_valid) begin
      d_cap.valid    = 1'b1;
      d_cap.pc       = id_pc;
      d_cap.reg1     = id_reg1;
      d_cap.reg2     = id_reg2;
      d_cap.imm      = id_imm;
      d_cap.use_imm  = id_use_imm;
      d_cap.cmd      = id_exe_cmd;
      d_cap.src1     = id_src1;
      d_cap.src2     = id_src2;
      d_cap.dest     = id_dest;
      d_cap.wb_en    = id_wb_en;
      d_cap.mem_r_en = id_mem_r_en;
      d_cap.mem_w_en = id_mem_w_en;
    end
  end

  // Pipeline register: reset and flush give a bubble, freeze holds, otherwise capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!freeze) begin
      q <= d_cap;
    end
  end

`ifdef FORWARDING_EN
  forwarding_unit #(.DW(DW)) u_fwd_src1 (
    .src        (q.src1),
    .reg_val    (q.reg1),
    .mem_wb_en  (mem_wb_en),
    .mem_dest   (mem_dest),
    .mem_result (mem_result),
    .wb_wb_en   (wb_wb_en),
    .wb_dest    (wb_dest),
    .wb_value   (wb_value),
    .value      (op1)
  );

  forwarding_unit #(.DW(DW)) u_fwd_src2 (
    .src        (q.src2),
    .reg_val    (q.reg2),
    .mem_wb_en  (mem_wb_en),
    .mem_dest   (mem_dest),
    .mem_result (mem_result),
    .wb_wb_en   (wb_wb_en),
    .wb_dest    (wb_dest),
    .wb_value   (wb_value),
    .value      (op2)
  );
`else
  // Without forwarding the operands are exactly the values read in decode.
  assign op1 = q.reg1;
  assign op2 = q.reg2;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{mem_wb_en, mem_dest, mem_result,
                               wb_wb_en, wb_dest, wb_value, q.src1, q.src2};
`endif

  // ALU operands and side-band; the command passes through untouched.
  always_comb begin
    alu_in1       = op1;
    alu_in2       = q.use_imm ? q.imm : op2;
    alu_cmd       = q.cmd;
    exe_store_val = op2;
    exe_valid     = q.valid;
    exe_pc        = q.pc;
    exe_dest      = q.dest;
    exe_wb_en     = q.wb_en;
    exe_mem_r_en  = q.mem_r_en;
    exe_mem_w_en  = q.mem_w_en;
  end

endmodule

// File: doc/id_exe_stage.md
ID_EXE_STAGE -- requirements
Module: id_exe_stage

Interface
REQ-001 Parameter: DW, 32, datapath width (register values, immediate, PC, ALU operands).
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: rst  in  1  asynchronous, active-low reset.
REQ-004 Port: freeze  in  1  hold all pipeline registers this cycle.
REQ-005 Port: flush  in  1  replace the incoming instruction with a bubble.
REQ-006 Ports: id_valid 1, id_pc DW, id_reg1 DW, id_reg2 DW, id_imm DW, id_use_imm 1, id_exe_cmd 4, id_src1 5, id_src2 5, id_dest 5, id_wb_en 1, id_mem_r_en 1, id_mem_w_en 1  in  decoded instruction.
REQ-007 Ports: mem_wb_en 1, mem_dest 5, mem_result DW  in  MEM-stage forwarding source.
REQ-008 Ports: wb_wb_en 1, wb_dest 5, wb_value DW  in  WB-stage forwarding source.
REQ-009 Ports: alu_in1 DW, alu_in2 DW, alu_cmd 4  out  ALU operands and 4-bit command.
REQ-010 Ports: exe_valid 1, exe_pc DW, exe_dest 5, exe_wb_en 1, exe_mem_r_en 1, exe_mem_w_en 1, exe_store_val DW  out  registered side-band to EXE/MEM.

Function
REQ-011 Register bank SHALL capture all id_* inputs on each rising clk when freeze=0 and flush=0; latency one cycle.
REQ-012 freeze=1, flush=0: registers SHALL hold; outputs recompute combinationally from held values and live forwarding inputs.
REQ-013 flush=1 SHALL win over freeze: next state exe_valid=0, exe_wb_en=0, exe_mem_r_en=0, exe_mem_w_en=0, alu_cmd=4'b0000, all data fields 0.
REQ-014 id_valid=0 captured SHALL yield the bubble state of REQ-013.
REQ-015 alu_cmd SHALL be the registered id_exe_cmd, unmodified; codes outside the ALU command set pass through.
REQ-016 Operand A: forwarded value of src1 (REQ-018).
REQ-017 Operand B: registered imm when use_imm=1, else forwarded value of src2; exe_store_val SHALL always be forwarded value of src2.
REQ-018 Forwarding per source index s: if mem_wb_en=1, mem_dest==s, s!=0 -> mem_result; else if wb_wb_en=1, wb_dest==s, s!=0 -> wb_value; else registered reg value. MEM beats WB when both match.
REQ-019 Source index 0 SHALL never forward; it always yields the registered value.
REQ-020 Forwarding muxes SHALL be combinational after the register (no added latency); load-use stalls are the hazard unit's job via freeze.
REQ-021 Only one instruction held at a time; no internal buffering beyond the single register stage.

Reset
REQ-022 rst=0 SHALL asynchronously force the bubble state of REQ-013, exe_pc=0, independent of clk.
REQ-023 Reset deassertion SHALL take effect at the next rising clk; first capture occurs on that edge.
REQ-024 Reset mid-freeze SHALL discard the held instruction.

Configuration
REQ-025 Macro FORWARDING_EN defined: REQ-018/019 forwarding compiled in.
REQ-026 FORWARDING_EN undefined: operands and exe_store_val SHALL come directly from registered reg1/reg2; mem_*/wb_* inputs ignored; all other behaviour unchanged.

Structure
REQ-027 Shared package mips_pkg SHALL hold ALU command constants (ADD 0000, SUB 0010, AND 0100, OR 0101, NOR 0110, XOR 0111, SLL 1000, SRA 1001, SRL 1010), register-index width 5, forwarding-select enum (FWD_REG, FWD_MEM, FWD_WB).
REQ-028 Forwarding select logic SHALL be one sub-module, forwarding_unit, instantiated once per source operand; absent when FORWARDING_EN undefined.

Verification
REQ-029 Load id_src1=3, reg1=5, src2=4, reg2=7, use_imm=0, cmd=0000, no forwarding matches -> next cycle alu_in1=5, alu_in2=7, alu_cmd=0000, exe_valid=1.
REQ-030 Held src1=3; mem_wb_en=1, mem_dest=3, mem_result=0x11; wb_wb_en=1, wb_dest=3, wb_value=0x22 -> alu_in1=0x11; drop mem_wb_en -> alu_in1=0x22 same cycle.
REQ-031 src2=0, wb_dest=0, wb_wb_en=1, wb_value=0xFF, reg2=0 -> alu_in2=0; use_imm=1, imm=0xFFFFFFFC -> alu_in2=0xFFFFFFFC, exe_store_val unchanged from forwarded src2.
REQ-032 freeze=1 for 3 cycles while id_* change -> outputs stable; freeze=1 with flush=1 -> next cycle exe_valid=0, exe_wb_en=0, exe_mem_w_en=0.
REQ-033 Assert rst=0 between clk edges with valid instruction held -> outputs bubble immediately, exe_pc=0; release -> capture resumes on next edge.
REQ-034 Build without FORWARDING_EN, repeat REQ-030 -> alu_in1 equals registered reg1 throughout.
